// File: rtl/tcore_param.sv
// Shared cache/memory interface types and the byte-strobe helper used by the
// memory arbiter and the dcache store path.
package tcore_param;

    localparam int TC_BLK_SIZE = 128;
    localparam int TC_XLEN     = 32;
    localparam int TC_STRB_W   = TC_BLK_SIZE / 8;
    localparam int MEM_TIMEOUT = 1024;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_e;
    typedef enum logic {GNT_ICACHE, GNT_DCACHE} arb_gnt_e;

    typedef struct packed {
        logic               valid;
        logic               ready;
        logic               rw;
        logic [TC_XLEN-1:0] addr;
    } lowX_req_t;

    typedef struct packed {
        logic                   valid;
        logic                   ready;
        logic [TC_BLK_SIZE-1:0] blk;
    } lowX_res_t;

    typedef struct packed {
        logic                   valid;
        logic                   ready;
        logic                   rw;
        logic                   uncached;
        logic [1:0]             rw_size;
        logic [TC_XLEN-1:0]     addr;
        logic [TC_BLK_SIZE-1:0] data;
    } dlowX_req_t;

    typedef struct packed {
        logic                   valid;
        logic                   ready;
        logic [TC_BLK_SIZE-1:0] data;
    } dlowX_res_t;

    typedef struct packed {
        logic                   valid;
        logic                   ready;
        logic [TC_STRB_W-1:0]   rw;
        logic [TC_XLEN-1:0]     addr;
        logic [TC_BLK_SIZE-1:0] data;
    } iomem_req_t;

    typedef struct packed {
        logic                   valid;
        logic                   ready;
        logic [TC_BLK_SIZE-1:0] data;
    } iomem_res_t;

    // Uncached stores touch only the addressed lanes; rw_size 3 behaves as a word.
    function automatic logic [15:0] strb_gen(input logic [3:0] addr,
                                             input logic [1:0] rw_size,
                                             input logic       rw,
                                             input logic       uncached);
        logic [15:0] strb;
        if (!rw) begin
            strb = 16'h0000;
        end else if (!uncached) begin
            strb = 16'hFFFF;
        end else begin
            case (rw_size)
                2'd0:    strb = 16'h0001 << addr;
                2'd1:    strb = 16'h0003 << {addr[3:1], 1'b0};
                default: strb = 16'h000F << {addr[3:2], 2'b00};
            endcase
        end
        return strb;
    endfunction

endpackage

// File: rtl/tcore_mem_arbiter.sv
// Round-robin arbiter sharing the external memory port between the icache and
// dcache miss paths; one outstanding transaction, all outputs registered.
module tcore_mem_arbiter
    import tcore_param::*;
#(
    parameter int BLK_SIZE = TC_BLK_SIZE,
    parameter int XLEN     = TC_XLEN,
    parameter int TIMEOUT  = MEM_TIMEOUT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  lowX_req_t  ireq_i,
    output lowX_res_t  ires_o,
    input  dlowX_req_t dreq_i,
    output dlowX_res_t dres_o,
    output iomem_req_t mreq_o,
    input  iomem_res_t mres_i,
    output logic       err_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    arb_state_e              state_q, state_d;
    arb_gnt_e                gnt_q, gnt_d, last_q, last_d;
    logic [XLEN-1:0]         addr_q, addr_d;
    logic [BLK_SIZE/8-1:0]   strb_q, strb_d;
    logic [BLK_SIZE-1:0]     wdata_q, wdata_d;
    logic [BLK_SIZE-1:0]     rdata_q, rdata_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    mvalid_q, mvalid_d, mready_q, mready_d;
    logic                    ready_q, ready_d;
    logic                    ivalid_q, ivalid_d, dvalid_q, dvalid_d;
    logic                    err_q, err_d;
    arb_gnt_e                win;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        addr_d   = addr_q;
        strb_d   = strb_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        mvalid_d = 1'b0;
        ivalid_d = 1'b0;
        dvalid_d = 1'b0;
        err_d    = 1'b0;
        win      = (ireq_i.valid && (!dreq_i.valid || last_q == GNT_DCACHE)) ? GNT_ICACHE
                                                                            : GNT_DCACHE;
        case (state_q)
            ARB_IDLE: begin
                if (ireq_i.valid || dreq_i.valid) begin
                    if (win == GNT_ICACHE) begin
                        addr_d  = {ireq_i.addr[XLEN-1:4], 4'b0000};
                        strb_d  = '0;
                        wdata_d = '0;
                    end else begin
                        addr_d  = dreq_i.uncached ? dreq_i.addr
                                                  : {dreq_i.addr[XLEN-1:4], 4'b0000};
                        strb_d  = strb_gen(dreq_i.addr[3:0], dreq_i.rw_size,
                                           dreq_i.rw, dreq_i.uncached);
                        wdata_d = dreq_i.rw ? dreq_i.data : '0;
                    end
                    gnt_d    = win;
                    last_d   = win;
                    mvalid_d = 1'b1;
                    state_d  = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                // A same-cycle mres_i.valid is not a response yet; only accept matters here.
                if (mres_i.ready) begin
                    state_d = ARB_WAIT;
                end else begin
                    mvalid_d = 1'b1;
                end
            end
            ARB_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mres_i.valid) begin
                    rdata_d  = mres_i.data;
                    ivalid_d = (gnt_q == GNT_ICACHE);
                    dvalid_d = (gnt_q == GNT_DCACHE);
                    state_d  = ARB_RESP;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    rdata_d  = '0;
                    err_d    = 1'b1;
                    ivalid_d = (gnt_q == GNT_ICACHE);
                    dvalid_d = (gnt_q == GNT_DCACHE);
                    state_d  = ARB_RESP;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ARB_IDLE;
            end
        endcase
        ready_d  = (state_d == ARB_IDLE);
        mready_d = (state_d == ARB_WAIT);
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst_i) begin
            state_q  <= ARB_IDLE;
            gnt_q    <= GNT_ICACHE;
            last_q   <= GNT_DCACHE;
            addr_q   <= '0;
            strb_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            mvalid_q <= 1'b0;
            mready_q <= 1'b0;
            ready_q  <= 1'b0;
            ivalid_q <= 1'b0;
            dvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            strb_q   <= strb_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            mvalid_q <= mvalid_d;
            mready_q <= mready_d;
            ready_q  <= ready_d;
            ivalid_q <= ivalid_d;
            dvalid_q <= dvalid_d;
            err_q    <= err_d;
        end
    end

    assign ires_o = '{valid: ivalid_q, ready: ready_q, blk: rdata_q};
    assign dres_o = '{valid: dvalid_q, ready: ready_q, data: rdata_q};
    assign mreq_o = '{valid: mvalid_q, ready: mready_q, rw: strb_q, addr: addr_q, data: wdata_q};
    assign err_o  = err_q;

    logic unused_inputs;
    assign unused_inputs = ^{ireq_i.ready, ireq_i.rw, ireq_i.addr[3:0], dreq_i.ready};

endmodule

// File: doc/tcore_mem_arbiter.md
Name: tcore_mem_arbiter

Overview:
- Shares the single external memory port (iomem_req_t/iomem_res_t) between the instruction-cache miss path (lowX_req_t/lowX_res_t) and the data-cache miss/writeback/uncached path (dlowX_req_t/dlowX_res_t).
- Round-robin grant, one outstanding memory transaction at a time.
- All requester and memory-side outputs are registered.
- Sits between the cache subsystem and the memory/peripheral interconnect.

Parameters:
- BLK_SIZE, 128, line width in bits; rw strobe width is BLK_SIZE/8 = 16.
- XLEN, 32, address width.
- TIMEOUT, 1024, max cycles in WAIT before forced error completion; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- ireq_i  in  lowX_req_t (35)  icache request; valid held until ires_o.valid
- ires_o  out  lowX_res_t (130)  icache response: valid pulse, ready, blk
- dreq_i  in  dlowX_req_t (166)  dcache request; valid held until dres_o.valid
- dres_o  out  dlowX_res_t (130)  dcache response: valid pulse, ready, data
- mreq_o  out  iomem_req_t (178)  memory request: valid, ready, rw strobes, addr, data
- mres_i  in  iomem_res_t (130)  memory response; .ready = accept, .valid = data return
- err_o  out  1  one-cycle pulse on watchdog timeout

Behaviour:
- Reset: all outputs 0, FSM=IDLE, last_grant=DCACHE (so icache wins the first tie), timeout counter=0. Reset mid-transaction abandons it; any late mres_i.valid is ignored, since it arrives outside WAIT.
- FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - ires_o.ready = dres_o.ready = 1.
  - Grant if any valid: single requester wins; both valid -> the one not equal to last_grant.
  - Latch the winner's fields into an internal request register; update last_grant; go to ISSUE.
  - Requester inputs are not sampled again until the next IDLE.
- ISSUE:
  - mreq_o.valid = 1 with latched fields; stays asserted until mres_i.ready = 1 (accept), then go to WAIT.
  - Fields are stable while valid is high.
- Address:
  - icache, or dcache cached (uncached=0): addr with [3:0] forced to 0.
  - dcache uncached: addr passed unmodified.
- Strobes (mreq_o.rw):
  - Read (icache, or dreq.rw=0): 16'h0000.
  - Cached dcache write: 16'hFFFF.
  - Uncached write, rw_size 0 (byte): 1 << addr[3:0].
  - rw_size 1 (half): 16'h3 << {addr[3:1],1'b0}.
  - rw_size 2 (word): 16'hF << {addr[3:2],2'b00}.
  - rw_size 3 treated as word.
- mreq_o.data = dreq.data for writes, 0 otherwise.
- WAIT:
  - Counter increments each cycle.
  - On mres_i.valid: capture mres_i.data, go to RESP.
  - If TIMEOUT != 0 and counter reaches TIMEOUT-1 without valid: capture data 0, pulse err_o, go to RESP.
- RESP:
  - Granted requester's res.valid = 1 for exactly one cycle with the captured blk/data; other res.valid = 0.
  - Clear counter; go to IDLE.
  - Requesters drop valid on the same edge, so IDLE sees fresh requests.
- Latency, cycles measured from the IDLE sample edge (mres_i.ready=1 on the first ISSUE cycle):
  - mreq_o.valid at +1.
  - Memory response at cycle M -> res.valid at M+1.
  - Next grant earliest at M+2.
- Simultaneous events: memory ready and valid asserted in the same cycle during ISSUE -> ISSUE exits on ready only; valid is expected in WAIT. The memory side guarantees response ≥1 cycle after accept.
- Fairness: strict alternation when both requesters are continuously pending. Each requester waits at most one foreign transaction.

Decomposition:
- tcore_param gains:
  - localparam MEM_TIMEOUT = 1024.
  - typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_e.
  - typedef enum logic {GNT_ICACHE, GNT_DCACHE} arb_gnt_e.
  - function strb_gen(addr[3:0], rw_size, rw, uncached) returning logic [15:0].
- No sub-module needed; strobe generation is the shared package function, so the dcache store path can reuse it.

Test Plan:
- Icache only: ireq addr 0x8000_0004 -> mreq addr 0x8000_0000, rw 0x0000 at +1. Memory ready immediately, returns blk 0xDEAD..BEEF 3 cycles later -> ires.valid one cycle with that blk; dres.valid stays 0.
- Both requesters valid in the same cycle after reset -> icache granted first. Both held continuously -> grants alternate I, D, I, D over 4 transactions.
- Uncached byte store: addr 0x2000_0007, rw_size 0 -> rw 0x0080. Half store at 0x...A -> 0x0C00. Word store at 0x...C -> 0xF000. Cached writeback -> 0xFFFF, addr[3:0] = 0.
- Memory holds mres.ready = 0 for 5 cycles -> mreq fields unchanged and valid held for all 5; accept on the 6th; no duplicate issue.
- TIMEOUT = 16, memory never responds -> err_o pulses once 16 cycles after accept; requester gets valid with data 0; FSM returns to IDLE and serves the next request.
- rst_i asserted in WAIT -> all outputs 0 next cycle. A late mres.valid after reset produces no res.valid. A new ireq after reset completes normally.
